accum_loop_unit: RTL and testbench
==================================

ACCUM_LOOP_UNIT -- requirements
Module: accum_loop_unit

Interface
REQ-001 Parameter DATA_W, default 8, accumulator and result width.
REQ-002 Parameter CNT_W, default 8, counter, start, limit and step width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-005 start  in  1  request a run; sampled only in IDLE.
REQ-006 abort  in  1  terminate the current run; ignored in IDLE.
REQ-007 mode  in  1  0 = arithmetic series sum; 1 = Fibonacci sequence.
REQ-008 start_val, limit, step  in  CNT_W each  loop bounds; sampled with start.
REQ-009 out_data  out  DATA_W  per-iteration result.
REQ-010 out_valid  out  1  one-cycle strobe qualifying out_data.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at run end.
REQ-013 ovf  out  1  sticky accumulator-overflow flag for the current run.

Function
REQ-014 The FSM SHALL have the states IDLE, INIT, CHECK, ACC, CNT, EMIT and DONE.
REQ-015 In IDLE with start=1: latch mode, start_val, limit and step (step=0 is latched as 1); clear ovf; go to INIT.
REQ-016 In IDLE with start=0: hold.
REQ-017 INIT: cnt<=start_val; mode 0: acc_a<=0; mode 1: acc_a<=0, acc_b<=1; then CHECK.
REQ-018 CHECK: cnt<=limit (unsigned) -> ACC; otherwise -> DONE.
REQ-019 ACC, mode 0: acc_a<=acc_a+cnt.
REQ-020 ACC, mode 1: acc_a<=acc_b and acc_b<=acc_a+acc_b, updated simultaneously.
REQ-021 In either mode, ACC then goes to CNT.
REQ-022 Accumulator sums SHALL wrap modulo 2^DATA_W; any carry-out SHALL set ovf, which holds until the next accepted start.
REQ-023 CNT: cnt<=cnt+step modulo 2^CNT_W; a carry-out SHALL set an internal wrap flag; then EMIT.
REQ-024 EMIT: out_valid=1 with out_data=acc_a for exactly one cycle.
REQ-025 EMIT exit: to DONE if the wrap flag is set; otherwise to CHECK.
REQ-026 DONE: done=1 for one cycle; clear the wrap flag; then IDLE.
REQ-027 out_data SHALL hold its last value until the next EMIT.
REQ-028 abort=1 in any non-IDLE state: next state is IDLE and no out_valid or done is produced that cycle.
REQ-029 abort has priority over every other transition.
REQ-030 start while busy SHALL be ignored and SHALL NOT alter the latched operands.
REQ-031 Latency: start accepted at cycle 0 -> first out_valid at cycle 5; each further iteration takes 4 cycles.
REQ-032 Empty run (start_val>limit): done at cycle 3 with no out_valid.
REQ-033 limit = 2^CNT_W-1 SHALL terminate only via counter wrap (REQ-023, REQ-025), never loop forever.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE and clear out_data, out_valid, busy, done, ovf, the wrap flag and all internal registers to 0, including mid-run.
REQ-035 rst_n SHALL take priority over abort and start.

Verification
REQ-036 Mode 0, start_val=0, limit=10, step=1 -> 11 out_valid strobes, out_data 0,1,3,6,10,15,21,28,36,45,55, 4 cycles apart; done 2 cycles after last strobe; ovf=0.
REQ-037 Mode 1, start_val=0, limit=5, step=1 -> out_data 1,1,2,3,5,8, then done.
REQ-038 Mode 0, start_val=250, limit=255, step=4 (defaults) -> out_data 250 then 248 with ovf=1; counter wraps; done follows the second EMIT.
REQ-039 start_val=12, limit=10 -> no out_valid; done at cycle 3; busy high for cycles 1-3.
REQ-040 step=0, start_val=0, limit=2 -> behaves as step=1: out_data 0,1,3.
REQ-041 abort in ACC, and rst_n=0 in CNT (separate runs) -> IDLE next cycle, no further strobes; rst_n case also clears all outputs; a following start runs normally.

Source files
------------

// File: rtl/accum_loop_unit_if.sv
// Control/result bundle for accum_loop_unit: run request, loop bounds and per-iteration results.
interface accum_loop_unit_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [CNT_W-1:0]  start_val;
    logic [CNT_W-1:0]  limit;
    logic [CNT_W-1:0]  step;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              ovf;

    modport master (
        output start, abort, mode, start_val, limit, step,
        input  out_data, out_valid, busy, done, ovf
    );

    modport slave (
        input  start, abort, mode, start_val, limit, step,
        output out_data, out_valid, busy, done, ovf
    );
endinterface

// File: rtl/accum_loop_unit.sv
// Counted loop engine: per iteration accumulates an arithmetic series (mode 0) or steps a
// Fibonacci pair (mode 1) and emits the running value; all outputs are registered.
module accum_loop_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    accum_loop_unit_if.slave   bus
);
    localparam int SW = ((DATA_W > CNT_W) ? DATA_W : CNT_W) + 1;

    typedef enum logic [2:0] {
        IDLE, INIT, CHECK, ACC, CNT, EMIT, DONE
    } state_t;

    state_t            state_q;
    logic              mode_q;
    logic [CNT_W-1:0]  start_val_q;
    logic [CNT_W-1:0]  limit_q;
    logic [CNT_W-1:0]  step_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] acc_a_q;
    logic [DATA_W-1:0] acc_b_q;
    logic              wrap_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    logic [SW-1:0]     ser_sum;
    logic [DATA_W:0]   fib_sum;
    logic [CNT_W:0]    cnt_sum;
    logic [DATA_W-1:0] acc_a_d;
    logic [DATA_W-1:0] acc_b_d;
    logic              acc_carry_d;

    assign ser_sum = SW'(acc_a_q) + SW'(cnt_q);
    assign fib_sum = {1'b0, acc_a_q} + {1'b0, acc_b_q};
    assign cnt_sum = {1'b0, cnt_q} + {1'b0, step_q};

    // Next accumulator pair for the ACC state; carry is any bit above the DATA_W result.
    always_comb begin
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        acc_carry_d = 1'b0;
        if (!mode_q) begin
            acc_a_d     = ser_sum[DATA_W-1:0];
            acc_carry_d = |ser_sum[SW-1:DATA_W];
        end else begin
            acc_a_d     = acc_b_q;
            acc_b_d     = fib_sum[DATA_W-1:0];
            acc_carry_d = fib_sum[DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            start_val_q <= '0;
            limit_q     <= '0;
            step_q      <= '0;
            cnt_q       <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            wrap_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (state_q != IDLE && bus.abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            mode_q      <= bus.mode;
                            start_val_q <= bus.start_val;
                            limit_q     <= bus.limit;
                            step_q      <= (bus.step == '0) ? CNT_W'(1) : bus.step;
                            ovf_q       <= 1'b0;
                            wrap_q      <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= INIT;
                        end
                    end
                    INIT: begin
                        cnt_q   <= start_val_q;
                        acc_a_q <= '0;
                        acc_b_q <= mode_q ? DATA_W'(1) : '0;
                        state_q <= CHECK;
                    end
                    CHECK: begin
                        if (cnt_q <= limit_q) begin
                            state_q <= ACC;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    ACC: begin
                        acc_a_q <= acc_a_d;
                        acc_b_q <= acc_b_d;
                        if (acc_carry_d) ovf_q <= 1'b1;
                        state_q <= CNT;
                    end
                    CNT: begin
                        // A counter carry is the only way out when limit is the maximum count.
                        cnt_q       <= cnt_sum[CNT_W-1:0];
                        if (cnt_sum[CNT_W]) wrap_q <= 1'b1;
                        out_data_q  <= acc_a_q;
                        out_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                    EMIT: begin
                        if (wrap_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                    DONE: begin
                        wrap_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_accum_loop_unit.sv
// Randomized bench for accum_loop_unit: a loop-level reference model queues expected strobes,
// a negedge monitor pops and compares them, and busy is tracked against the expected run window.
module tb_accum_loop_unit;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int DMAX = 1 << DW;
    localparam int CMAX = 1 << CW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_loop_unit_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    accum_loop_unit #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit is_done;
        int data;
        bit ovf;
        int cyc;
    } ev_t;

    ev_t expq[$];
    int  cyc       = 0;
    int  passed    = 0;
    int  total     = 0;
    int  busy_lo   = 1;
    int  busy_hi   = 0;
    int  last_data = 0;
    bit  mon_en    = 1'b0;
    int  run_no    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: one comparison set per observed strobe, plus busy and held-data tracking.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            check("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (bus.out_valid || bus.done) begin
                if (expq.size() == 0) begin
                    check(bus.done ? "unexpected_done" : "unexpected_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("event_kind_done", bus.done, e.is_done);
                    check("event_cycle", cyc, e.cyc);
                    check("ovf", bus.ovf, e.ovf);
                    if (!e.is_done) begin
                        check("out_data", bus.out_data, e.data);
                        last_data = e.data;
                    end
                end
            end else begin
                check("out_data_hold", bus.out_data, last_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // kill: 0 none, 1 abort during ACC of iteration kill_iter, 2 reset during CNT of kill_iter.
    task automatic run(input bit m, input int sv, input int lim, input int st,
                       input int kill, input int kill_iter, input bit junk);
        ev_t evs[$];
        ev_t e;
        int  c, a, b, s2, k, st_eff, d_rel, end_rel, kill_cyc, s;
        bit  ov, wrapped;
        c = sv; a = 0; b = m ? 1 : 0; k = 0; ov = 0; wrapped = 0;
        st_eff = (st == 0) ? 1 : st;
        while (c <= lim) begin
            if (!m) begin
                s2 = a + c;
                if (s2 >= DMAX) ov = 1;
                a = s2 % DMAX;
            end else begin
                s2 = a + b;
                if (s2 >= DMAX) ov = 1;
                a = b;
                b = s2 % DMAX;
            end
            e.is_done = 0; e.data = a; e.ovf = ov; e.cyc = 5 + 4 * k;
            evs.push_back(e);
            c = c + st_eff;
            if (c >= CMAX) begin
                wrapped = 1;
                break;
            end
            k++;
        end
        d_rel = wrapped ? (6 + 4 * k) : (3 + 4 * k);
        e.is_done = 1; e.data = 0; e.ovf = ov; e.cyc = d_rel;
        evs.push_back(e);
        kill_cyc = (kill == 1) ? (3 + 4 * kill_iter) : (4 + 4 * kill_iter);
        end_rel  = (kill != 0) ? kill_cyc : d_rel;

        s = cyc;
        foreach (evs[i]) begin
            if (kill == 0 || evs[i].cyc < kill_cyc) begin
                e = evs[i];
                e.cyc = e.cyc + s;
                expq.push_back(e);
            end
        end
        busy_lo = s + 1;
        busy_hi = s + end_rel;
        bus.mode = m; bus.start_val = CW'(sv); bus.limit = CW'(lim); bus.step = CW'(st);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int r = 1; r <= end_rel + 1; r++) begin
            if (junk && r <= end_rel) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.mode      = 1'($urandom_range(0, 1));
                bus.start_val = CW'($urandom);
                bus.limit     = CW'($urandom);
                bus.step      = CW'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (kill == 1 && r == kill_cyc) bus.abort = 1'b1;
            if (kill == 2 && r == kill_cyc) rst_n = 1'b0;
            tick();
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (kill == 2 && r == kill_cyc) begin
                rst_n = 1'b1;
                last_data = 0;
                check("rst_out_data", bus.out_data, 0);
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.done, 0);
                check("rst_ovf", bus.ovf, 0);
            end
        end
        tick();
        check("events_left", expq.size(), 0);
        expq.delete();
        $display("run %0d: mode=%0d start_val=%0d limit=%0d step=%0d kill=%0d expected_strobes=%0d",
                 run_no, m, sv, lim, st, kill, evs.size());
        run_no++;
    endtask

    initial begin
        int lim, sv, st;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
        bus.start_val = '0; bus.limit = '0; bus.step = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_out_data", bus.out_data, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        run(0, 0, 10, 1, 0, 0, 0);      // series 0..10
        run(1, 0, 5, 1, 0, 0, 0);       // Fibonacci
        run(0, 250, 255, 4, 0, 0, 0);   // overflow and counter wrap
        run(0, 12, 10, 1, 0, 0, 0);     // empty run
        run(0, 0, 2, 0, 0, 0, 0);       // step 0 treated as 1
        run(0, 250, 255, 1, 0, 0, 0);   // limit at maximum count
        run(0, 0, 10, 1, 1, 2, 0);      // abort in ACC
        run(0, 0, 5, 1, 0, 0, 0);
        run(1, 0, 10, 1, 2, 1, 0);      // reset in CNT
        run(1, 0, 5, 1, 0, 0, 1);       // start while busy ignored

        for (int n = 0; n < 30; n++) begin
            lim = $urandom_range(0, CMAX - 1);
            if ($urandom_range(0, 7) == 0) sv = $urandom_range(0, CMAX - 1);
            else if (lim >= 40) sv = lim - $urandom_range(0, 40);
            else sv = $urandom_range(0, lim);
            st = $urandom_range(0, 7);
            run(1'($urandom_range(0, 1)), sv, lim, st, 0, 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
